// File: rtl/fg_cfg_sequencer_if.sv
// Byte-stream handshake feeding the configuration sequencer.
// Source drives data/valid, sink answers with ready.
interface fg_cfg_sequencer_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_ready_o;

  modport master (
    output s_data_i,
    output s_valid_i,
    input  s_ready_o
  );

  modport slave (
    input  s_data_i,
    input  s_valid_i,
    output s_ready_o
  );
endinterface

// File: rtl/fg_cfg_sequencer.sv
// Loads consecutive generator config registers from a byte stream,
// pausing the generator and pacing pins for its input synchronizers.
module fg_cfg_sequencer #(
  parameter int SETTLE    = 3,
  parameter int WR_CYCLES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [2:0]          start_addr_i,
  input  logic [2:0]          len_i,
  input  logic                run_i,
  fg_cfg_sequencer_if.slave   s,
  output logic [7:0]          cfg_data_o,
  output logic [2:0]          cfg_addr_o,
  output logic                cfg_wr_n_o,
  output logic                cfg_en_n_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    IDLE,
    DISABLE,
    WAIT_BYTE,
    WRITE,
    HOLD
  } state_t;

  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] WR_LAST  = 8'(WR_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam bit         TO_EN    = (TIMEOUT != 0);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] addr;
  logic [2:0] rem;
  logic       xfer;
  logic       to_hit;

  assign s.s_ready_o = (state == WAIT_BYTE);
  assign busy_o      = (state != IDLE);
  assign xfer        = s.s_valid_i & s.s_ready_o;
  assign to_hit      = TO_EN && !xfer && (cnt == TO_LAST);

  // One counter serves every timed state; it is cleared on each entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      addr       <= 3'd0;
      rem        <= 3'd0;
      cfg_data_o <= 8'd0;
      cfg_addr_o <= 3'd0;
      cfg_wr_n_o <= 1'b1;
      cfg_en_n_o <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          cfg_wr_n_o <= 1'b1;
          cfg_en_n_o <= ~run_i;
          if (start_i && len_i != 3'd0) begin
            addr       <= start_addr_i;
            rem        <= len_i;
            cnt        <= 8'd0;
            cfg_en_n_o <= 1'b1;
            state      <= DISABLE;
          end
        end
        DISABLE: begin
          if (cnt == SET_LAST) begin
            cnt   <= 8'd0;
            state <= WAIT_BYTE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_BYTE: begin
          unique case (1'b1)
            xfer: begin
              cfg_data_o <= s.s_data_i;
              cfg_addr_o <= addr;
              cfg_wr_n_o <= 1'b0;
              cnt        <= 8'd0;
              state      <= WRITE;
            end
            to_hit: begin
              err_o      <= 1'b1;
              cfg_en_n_o <= ~run_i;
              state      <= IDLE;
            end
            default: cnt <= cnt + 8'd1;
          endcase
        end
        WRITE: begin
          if (cnt == WR_LAST) begin
            cfg_wr_n_o <= 1'b1;
            cnt        <= 8'd0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cnt == SET_LAST) begin
            cnt  <= 8'd0;
            addr <= addr + 3'd1;
            rem  <= rem - 3'd1;
            if (rem == 3'd1) begin
              done_o     <= 1'b1;
              cfg_en_n_o <= ~run_i;
              state      <= IDLE;
            end else begin
              state <= WAIT_BYTE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fg_cfg_sequencer.md
# fg_cfg_sequencer

Autonomous loader for the function generator's configuration register file. It accepts a byte stream over a valid/ready handshake and drives the generator's register-control pins to write consecutive registers: enable, write strobe and 3-bit address, all active-low where noted. Every pin transition is timed so it survives the generator's 2-stage input synchronizers. The block sits between a host-side byte source (UART/SPI front end or test ROM) and the generator's register-control inputs. It pauses the generator for the duration of the load and restores the run state afterwards.

## Interface
- SETTLE, 3: cycles each control-pin level is held before the next dependent pin changes; must be ≥ synchronizer stages + 1; range 1..255
- WR_CYCLES, 4: cycles the write strobe is held low per byte; range 1..255
- TIMEOUT, 255: max cycles waiting for a byte before abort; 0 = never time out; range 0..255

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  load request pulse; sampled only in IDLE
- start_addr_i  in  3  first register address; sampled with start_i
- len_i  in  3  number of bytes to load; 0 = request ignored
- run_i  in  1  desired generator run state when not loading (1 = running)
- s_data_i  in  8  config byte
- s_valid_i  in  1  byte valid
- s_ready_o  out  1  byte accepted when s_valid_i & s_ready_o at clk edge
- cfg_data_o  out  8  register data to generator
- cfg_addr_o  out  3  register address to generator
- cfg_wr_n_o  out  1  write strobe, active low
- cfg_en_n_o  out  1  generator enable, active low; high = stopped and register writes permitted
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse, load completed
- err_o  out  1  one-cycle pulse, load aborted by timeout

## Operation
- States: IDLE, DISABLE, WAIT_BYTE, WRITE, HOLD.
- IDLE
  - cfg_en_n_o = ~run_i, registered one cycle.
  - cfg_wr_n_o = 1; s_ready_o = 0.
  - start_i & len_i≠0 → latch start_addr_i and len_i, go DISABLE.
  - start_i with len_i=0 → no effect.
  - start_i outside IDLE → ignored.
- DISABLE: cfg_en_n_o = 1 for SETTLE cycles, then go WAIT_BYTE.
- WAIT_BYTE
  - s_ready_o = 1; cfg_en_n_o stays 1.
  - On transfer: register s_data_i into cfg_data_o, drive cfg_addr_o = current address, go WRITE.
  - Wait counter increments each cycle without transfer. When TIMEOUT≠0 and counter reaches TIMEOUT: pulse err_o, go IDLE. Registers already written stay written.
- WRITE: cfg_wr_n_o = 0 for WR_CYCLES cycles; cfg_data_o and cfg_addr_o stable.
- HOLD
  - cfg_wr_n_o = 1 for SETTLE cycles; data and address still stable.
  - Then address += 1 (mod 8, 7 wraps to 0) and remaining count −= 1.
  - remaining ≠ 0 → WAIT_BYTE; remaining = 0 → IDLE with done_o pulse.
- Address 7 is written like any other address; the generator ignores it.
- busy_o = 1 in every state except IDLE.
- cfg_data_o and cfg_addr_o change only on a WAIT_BYTE transfer; they hold their last values in IDLE.
- All outputs are registered except s_ready_o and busy_o, which decode from state. No glitches on the cfg_* pins.

## Timing
- Reset values: cfg_en_n_o=1, cfg_wr_n_o=1, cfg_data_o=0, cfg_addr_o=0, s_ready_o=0, busy_o=0, done_o=0, err_o=0, state IDLE.
- Reset mid-operation aborts immediately with no done/err pulse. Partial writes are not rolled back.
- After reset, cfg_en_n_o follows ~run_i from the second cycle onward.
- start_i sampled at edge E0 → busy_o=1 and cfg_en_n_o=1 from the cycle after E0.
- Per-byte cost with s_valid_i continuously high: 1 (WAIT_BYTE) + WR_CYCLES + SETTLE cycles.
- Load latency with no stalls: SETTLE + n·(1+WR_CYCLES+SETTLE) cycles after E0; done_o is high in that cycle and busy_o falls with it. Defaults: 3 + 8n, so n=7 takes 59 cycles.
- cfg_en_n_o returns to ~run_i in the cycle done_o or err_o is high.
- cfg_wr_n_o never goes low while cfg_en_n_o is 0.
- cfg_addr_o and cfg_data_o never change within SETTLE cycles after a cfg_wr_n_o rising edge.
- Wait counter clears on every WAIT_BYTE entry.

## Test plan
- Default params, run_i=1, start_addr=0, len=7, bytes 61,40,68,00,00,00,32 with valid always high → seven 4-cycle wr_n lows at addr 0..6 carrying the listed data; en_n high throughout; done_o exactly 59 cycles after the start edge; en_n=0 on the next cycle.
- Same load with s_valid_i gaps of 0, 5 and 20 cycles → s_ready_o high only in WAIT_BYTE; no byte lost or duplicated; done delayed by exactly the gap total.
- start_addr=6, len=3, bytes AA,BB,CC → writes at addr 6, 7, 0 in order; done pulse.
- TIMEOUT=10, len=2, one byte then silence → first write completes; err_o pulses 10 cycles after WAIT_BYTE re-entry; no done_o; en_n returns to ~run_i.
- len=0 start → busy_o stays 0. Second start while busy → ignored; the original load finishes unchanged.
- rst_n low during WRITE → next cycle wr_n=1, en_n=1, busy=0, data/addr=0; a fresh load afterwards completes normally.
